// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16x10 FIFO controller and its pointer counters.
package fifo_pkg;

    localparam int unsigned PTR_W  = 4;
    localparam int unsigned DEPTH  = 1 << PTR_W;
    localparam int unsigned DATA_W = 10;

    typedef logic [PTR_W:0] count_t;

    localparam count_t UMBRAL_ALTO_DEF = count_t'(12);
    localparam count_t UMBRAL_BAJO_DEF = count_t'(4);

    // Occupancy step: +1 on write only, -1 on read only, hold otherwise.
    function automatic count_t count_step(count_t cur, logic inc, logic dec);
        count_t nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + count_t'(1);
        end else if (dec && !inc) begin
            nxt = cur - count_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ptr_counter.sv
// Wrapping address counter with synchronous active-high reset and count enable.
module ptr_counter
    import fifo_pkg::*;
#(
    parameter int unsigned Width = fifo_pkg::PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [Width-1:0] value
);

    logic [Width-1:0] value_q;
    logic [Width-1:0] value_d;

    // Natural overflow of the Width-bit add gives the wrap to 0.
    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = value_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for the memoria FIFO storage array.
// Define FIFO_CTRL_ERR_EN to add the sticky overflow/underflow outputs.
module fifo_control
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_W  = fifo_pkg::PTR_W,
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PTR_W:0]   umbral_alto,
    input  logic [PTR_W:0]   umbral_bajo,
    output logic             wr_en,
    output logic             rd_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             valid_out
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [PTR_W:0] CountFull = {1'b1, {PTR_W{1'b0}}};

    if (PTR_W < 1 || DATA_W < 1) begin : g_bad_param
        $error("fifo_control: PTR_W and DATA_W must be at least 1");
    end

    logic [PTR_W:0] count_q;
    logic [PTR_W:0] count_d;
    logic           valid_q;
    logic           valid_d;

    // Flags decode the registered count only, so strobes never depend on this cycle's requests.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CountFull);
        almost_full  = (count_q >= umbral_alto);
        almost_empty = (count_q <= umbral_bajo);
    end

    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (!reset) begin
            wr_en = push & ~full;
            rd_en = pop & ~empty;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    ptr_counter #(
        .Width (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .value (wr_ptr)
    );

    ptr_counter #(
        .Width (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en),
        .value (rd_ptr)
    );

    assign count     = count_q;
    assign valid_out = valid_q;

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Raw requests against the registered flags; a dropped push or pop is what gets recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (push & full);
            underflow_q <= underflow_q | (pop & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    count_in_range: assert property (@(posedge clk) disable iff (reset)
        count_q <= CountFull);

    no_write_when_full: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && full));

    no_read_when_empty: assert property (@(posedge clk) disable iff (reset)
        !(rd_en && empty));

endmodule
